// File: rtl/lsu_if.sv
// Request/response and data-memory bundle for the load/store unit.
// The slave modport is the LSU's view; master is the pipeline plus dmem side.
interface lsu_if;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        fault;
    logic        mem_we;
    logic [2:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, fault,
        output mem_we, mem_size, mem_addr, mem_wd
    );

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, fault,
        input  mem_we, mem_size, mem_addr, mem_wd
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit: sub-word loads with extension, read-modify-write sub-word stores.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned H/W accesses instead of aligning them.
module lsu #(
    parameter int DMEM_POWER = 18
) (
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);

    typedef enum logic {IDLE, RMW} state_t;

    localparam logic [32:0] ADDR_LIMIT = 33'd1 << (DMEM_POWER + 2);

    state_t      state_reg;
    logic [31:0] rmw_word_reg;
    logic [31:0] rmw_addr_reg;
    logic [15:0] rmw_wdata_reg;
    logic [1:0]  rmw_off_reg;
    logic        rmw_half_reg;
    logic        resp_valid_reg;
    logic        fault_reg;
    logic [31:0] resp_rdata_reg;

    logic        accept;
    logic        size_illegal;
    logic        out_of_range;
    logic        misaligned;
    logic        req_fault;
    logic        subword_store;
    logic [1:0]  offset;
    logic [31:0] shifted;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    always_comb begin
        accept        = bus.req_valid && (state_reg == IDLE);
        size_illegal  = (bus.req_size == 3'b011) || (bus.req_size == 3'b110) ||
                        (bus.req_size == 3'b111) || (bus.req_we && bus.req_size[2]);
        out_of_range  = {1'b0, bus.req_addr} >= ADDR_LIMIT;
`ifdef LSU_MISALIGN_TRAP_EN
        misaligned    = ((bus.req_size[1:0] == 2'b01) && bus.req_addr[0]) ||
                        ((bus.req_size[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
        misaligned    = 1'b0;
`endif
        req_fault     = size_illegal || out_of_range || misaligned;
        subword_store = bus.req_we && !bus.req_size[1];

        // Offsets snap to natural alignment; with trapping on, the unaligned cases fault anyway.
        case (bus.req_size[1:0])
            2'b00:   offset = bus.req_addr[1:0];
            2'b01:   offset = {bus.req_addr[1], 1'b0};
            default: offset = 2'b00;
        endcase

        shifted = bus.mem_rd >> {offset, 3'b000};
        case (bus.req_size)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_data = {24'd0, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_data = {16'd0, shifted[15:0]};
            default: load_data = bus.mem_rd;
        endcase
    end

    // Byte-lane merge of the latched store data into the word read in the previous cycle.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       lane_sel;
            logic [7:0] lane_data;
            assign lane_sel  = rmw_half_reg ? (rmw_off_reg[1] == LANE[1]) : (rmw_off_reg == LANE);
            assign lane_data = (rmw_half_reg && LANE[0]) ? rmw_wdata_reg[15:8] : rmw_wdata_reg[7:0];
            assign merged_word[gi*8 +: 8] = lane_sel ? lane_data : rmw_word_reg[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        bus.mem_size = 3'b010;
        if (state_reg == RMW) begin
            bus.mem_addr = rmw_addr_reg;
            bus.mem_wd   = merged_word;
            bus.mem_we   = !rst;
        end else begin
            bus.mem_addr = {bus.req_addr[31:2], 2'b00};
            bus.mem_wd   = bus.req_wdata;
            bus.mem_we   = !rst && accept && !req_fault && bus.req_we && (bus.req_size == 3'b010);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            rmw_word_reg   <= '0;
            rmw_addr_reg   <= '0;
            rmw_wdata_reg  <= '0;
            rmw_off_reg    <= '0;
            rmw_half_reg   <= 1'b0;
            resp_valid_reg <= 1'b0;
            fault_reg      <= 1'b0;
            resp_rdata_reg <= '0;
        end else begin
            resp_valid_reg <= 1'b0;
            fault_reg      <= 1'b0;
            resp_rdata_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (req_fault) begin
                            resp_valid_reg <= 1'b1;
                            fault_reg      <= 1'b1;
                        end else if (subword_store) begin
                            rmw_word_reg  <= bus.mem_rd;
                            rmw_addr_reg  <= {bus.req_addr[31:2], 2'b00};
                            rmw_wdata_reg <= bus.req_wdata[15:0];
                            rmw_off_reg   <= offset;
                            rmw_half_reg  <= bus.req_size[0];
                            state_reg     <= RMW;
                        end else begin
                            resp_valid_reg <= 1'b1;
                            if (!bus.req_we) begin
                                resp_rdata_reg <= load_data;
                            end
                        end
                    end
                end
                RMW: begin
                    resp_valid_reg <= 1'b1;
                    state_reg      <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state_reg == IDLE);
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_rdata = resp_rdata_reg;
    assign bus.fault      = fault_reg;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: vector table for single transactions, hand sequences for
// back-to-back RMW, load-after-RMW and reset during RMW.
module tb_lsu;

    logic clk;
    logic rst;
    lsu_if bus ();

    lsu #(.DMEM_POWER(18)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    int we_count;
    assign bus.mem_rd = mem[bus.mem_addr[11:2]];

    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_addr[11:2]] = bus.mem_wd;
            we_count = we_count + 1;
        end
    end

    int n_checks;
    int n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_size  = size;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
    endtask

    // One transaction: lat counts cycles from the acceptance edge to the resp_valid sample.
    task automatic xact(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic flt, output int lat);
        int guard;
        @(negedge clk);
        drive(we, size, addr, wdata);
        guard = 0;
        while (!bus.req_ready && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 0;
        while (!bus.resp_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdata = bus.resp_rdata;
        flt   = bus.fault;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        int          exp_lat;
        int          exp_wes;
        logic [31:0] exp_word;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    initial begin
        logic [31:0] rd;
        logic        fl;
        int          lat;
        int          we0;

        n_checks = 0;
        n_fail   = 0;
        we_count = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[32'h100 >> 2] = 32'h8000_7F80;
        mem[32'h200 >> 2] = 32'h1122_3344;
        mem[32'h300 >> 2] = 32'hCAFE_F00D;
        mem[32'h400 >> 2] = 32'h1122_3344;
        mem[32'h500 >> 2] = 32'h1122_3344;
        mem[1023]         = 32'hA500_0000;

        //            we    size    addr           wdata          rdata          flt  lat wes word
        vecs[0]  = '{1'b0, 3'b000, 32'h0000_0100, 32'h0,         32'hFFFF_FF80, 1'b0, 0, 0, 32'h8000_7F80};
        vecs[1]  = '{1'b0, 3'b100, 32'h0000_0103, 32'h0,         32'h0000_0080, 1'b0, 0, 0, 32'h8000_7F80};
        vecs[2]  = '{1'b0, 3'b001, 32'h0000_0102, 32'h0,         32'hFFFF_8000, 1'b0, 0, 0, 32'h8000_7F80};
        vecs[3]  = '{1'b0, 3'b101, 32'h0000_0100, 32'h0,         32'h0000_7F80, 1'b0, 0, 0, 32'h8000_7F80};
        vecs[4]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,         32'h8000_7F80, 1'b0, 0, 0, 32'h8000_7F80};
        vecs[5]  = '{1'b1, 3'b000, 32'h0000_0201, 32'h1234_56AB, 32'h0,         1'b0, 1, 1, 32'h1122_AB44};
        vecs[6]  = '{1'b0, 3'b010, 32'h0000_0200, 32'h0,         32'h1122_AB44, 1'b0, 0, 0, 32'h1122_AB44};
        vecs[7]  = '{1'b1, 3'b001, 32'h0000_0402, 32'hFFFF_BEEF, 32'h0,         1'b0, 1, 1, 32'hBEEF_3344};
        vecs[8]  = '{1'b0, 3'b101, 32'h0000_0402, 32'h0,         32'h0000_BEEF, 1'b0, 0, 0, 32'hBEEF_3344};
        vecs[9]  = '{1'b0, 3'b000, 32'h0000_0403, 32'h0,         32'hFFFF_FFBE, 1'b0, 0, 0, 32'hBEEF_3344};
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[10] = '{1'b1, 3'b010, 32'h0000_0102, 32'hDEAD_BEEF, 32'h0,         1'b1, 0, 0, 32'h8000_7F80};
        vecs[11] = '{1'b0, 3'b011, 32'h0000_0100, 32'h0,         32'h0,         1'b1, 0, 0, 32'h8000_7F80};
        vecs[15] = '{1'b0, 3'b001, 32'h0000_0101, 32'h0,         32'h0,         1'b1, 0, 0, 32'h8000_7F80};
`else
        vecs[10] = '{1'b1, 3'b010, 32'h0000_0102, 32'hDEAD_BEEF, 32'h0,         1'b0, 0, 1, 32'hDEAD_BEEF};
        vecs[11] = '{1'b0, 3'b011, 32'h0000_0100, 32'h0,         32'h0,         1'b1, 0, 0, 32'hDEAD_BEEF};
        vecs[15] = '{1'b0, 3'b001, 32'h0000_0101, 32'h0,         32'hFFFF_BEEF, 1'b0, 0, 0, 32'hDEAD_BEEF};
`endif
        vecs[12] = '{1'b1, 3'b010, 32'h0010_0000, 32'hDEAD_BEEF, 32'h0,         1'b1, 0, 0, 32'h0};
        vecs[13] = '{1'b0, 3'b100, 32'h000F_FFFF, 32'h0,         32'h0000_00A5, 1'b0, 0, 0, 32'hA500_0000};
        vecs[14] = '{1'b1, 3'b100, 32'h0000_0200, 32'h0000_0077, 32'h0,         1'b1, 0, 0, 32'h1122_AB44};
        vecs[16] = '{1'b1, 3'b110, 32'h0000_0200, 32'h0000_0077, 32'h0,         1'b1, 0, 0, 32'h1122_AB44};

        // Reset state, with a word store presented that must not reach memory.
        rst = 1'b1;
        drive(1'b1, 3'b010, 32'h0000_0000, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_rdata", bus.resp_rdata, 32'd0);
        chk("rst_fault", 32'(bus.fault), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_no_write", 32'(we_count), 32'd0);
        $display("reset: ready=%0d resp_valid=%0d mem_we_pulses=%0d", bus.req_ready, bus.resp_valid, we_count);

        for (int i = 0; i < NV; i++) begin
            we0 = we_count;
            xact(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata, rd, fl, lat);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("v%0d_fault", i), 32'(fl), 32'(vecs[i].exp_fault));
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_we_pulses", i), 32'(we_count - we0), 32'(vecs[i].exp_wes));
            chk($sformatf("v%0d_mem_word", i), mem[vecs[i].addr[11:2]], vecs[i].exp_word);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pulse_end", i), 32'(bus.resp_valid), 32'd0);
            $display("vec %0d: we=%0d size=%b addr=%h wdata=%h -> rdata=%h fault=%0d lat=%0d",
                     i, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata, rd, fl, lat);
        end

        // Idle: no request means no write and no response.
        we0 = we_count;
        @(negedge clk);
        drive(1'b1, 3'b010, 32'h0000_0300, 32'h0BAD_0BAD);
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("idle_no_write", 32'(we_count - we0), 32'd0);
        $display("idle: resp_valid=%0d we_pulses=%0d", bus.resp_valid, we_count - we0);

        // SH then a back-to-back SB held for one cycle, then a load right after the RMW write.
        we0 = we_count;
        @(negedge clk);
        drive(1'b1, 3'b001, 32'h0000_0502, 32'h0000_BEEF);
        @(posedge clk);
        #1;
        chk("b2b_sh_ready_low", 32'(bus.req_ready), 32'd0);
        chk("b2b_sh_no_resp", 32'(bus.resp_valid), 32'd0);
        drive(1'b1, 3'b000, 32'h0000_0500, 32'h0000_0066);
        @(posedge clk);
        #1;
        chk("b2b_sh_resp", 32'(bus.resp_valid), 32'd1);
        chk("b2b_sb_ready", 32'(bus.req_ready), 32'd1);
        chk("b2b_sh_word", mem[32'h500 >> 2], 32'hBEEF_3344);
        @(posedge clk);
        #1;
        chk("b2b_sb_ready_low", 32'(bus.req_ready), 32'd0);
        chk("b2b_sb_no_resp", 32'(bus.resp_valid), 32'd0);
        drive(1'b0, 3'b010, 32'h0000_0500, 32'h0);
        @(posedge clk);
        #1;
        chk("b2b_sb_resp", 32'(bus.resp_valid), 32'd1);
        chk("b2b_sb_word", mem[32'h500 >> 2], 32'hBEEF_3366);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("b2b_lw_resp", 32'(bus.resp_valid), 32'd1);
        chk("b2b_lw_rdata", bus.resp_rdata, 32'hBEEF_3366);
        chk("b2b_lw_fault", 32'(bus.fault), 32'd0);
        chk("b2b_we_pulses", 32'(we_count - we0), 32'd2);
        @(posedge clk);
        #1;
        chk("b2b_lw_pulse_end", 32'(bus.resp_valid), 32'd0);
        $display("b2b: SH 0x502, SB 0x500, LW 0x500 -> word=%h we_pulses=%0d", mem[32'h500 >> 2], we_count - we0);

        // Reset during the RMW cycle of SB 0x55 to 0x300 abandons the write.
        we0 = we_count;
        @(negedge clk);
        drive(1'b1, 3'b000, 32'h0000_0300, 32'h0000_0055);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("rmw_rst_in_rmw", 32'(bus.req_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("rmw_rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rmw_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rmw_rst_mem_we", 32'(bus.mem_we), 32'd0);
        @(posedge clk);
        #1;
        chk("rmw_rst_word", mem[32'h300 >> 2], 32'hCAFE_F00D);
        chk("rmw_rst_no_write", 32'(we_count - we0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rmw_rst_after_resp", 32'(bus.resp_valid), 32'd0);
        chk("rmw_rst_after_ready", 32'(bus.req_ready), 32'd1);
        $display("rst in rmw: word=%h ready=%0d resp_valid=%0d", mem[32'h300 >> 2], bus.req_ready, bus.resp_valid);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the pipeline MEM stage and the word-addressed data memory (`dmem`). Converts byte/halfword/word requests (RISC-V funct3 encoding) into word-aligned memory accesses: it extracts and sign/zero-extends load data, performs two-cycle read-modify-write for sub-word stores, and flags misaligned or illegal accesses. It stalls the pipeline through a ready/valid handshake while a read-modify-write is in flight.

## Interface
- `DMEM_POWER`, 18: log2 of memory depth in words; byte addresses at or above `1 << (DMEM_POWER+2)` fault.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  MEM stage presents a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; stores use 000/001/010 only.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; the value occupies the low bits.
- `req_ready`  out  1  request accepted this cycle when `req_valid & req_ready`; low stalls the pipeline.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and faults.
- `fault`  out  1  qualifies `resp_valid`; access was suppressed.
- `mem_we`  out  1  to dmem write enable.
- `mem_size`  out  3  to dmem; always 010.
- `mem_addr`  out  32  to dmem; bits [1:0] always 00.
- `mem_wd`  out  32  to dmem write data.
- `mem_rd`  in  32  from dmem; combinational read of `mem_addr`.

## Operation
- FSM states: IDLE, RMW. `req_ready` = (state == IDLE).
- IDLE, accepted load: `mem_addr` = {req_addr[31:2],2'b00}. The byte/half at the `req_addr` offset is selected from `mem_rd`, extended per size (B/H sign, BU/HU zero, W as-is), and registered into `resp_rdata`. Stay in IDLE.
- IDLE, accepted word store: `mem_we`=1, `mem_wd`=req_wdata in the same cycle. Stay in IDLE.
- IDLE, accepted B/H store: read cycle (`mem_we`=0). Latch `mem_rd`, word address, offset, size, and `req_wdata` into internal registers, then go to RMW.
- RMW: `mem_we`=1, `mem_addr`=latched address, `mem_wd`=latched word with the target byte/half replaced by `wdata[7:0]`/`wdata[15:0]`. Go to IDLE.
- Fault conditions are checked at acceptance, in this priority order:
  - illegal size: 011, 110, 111 for any access; 100, 101 for a store;
  - out of range;
  - misaligned (see Configuration).
- On fault: no `mem_we` is issued and the FSM stays in IDLE.
- Outputs other than `mem_*` are registered. `mem_*` are combinational from state and request.

## Timing
- Reset values: state=IDLE, `resp_valid`=0, `resp_rdata`=0, `fault`=0. `mem_we`=0 while `rst` is high.
- Load: `resp_valid` pulses one cycle after acceptance. A new request is accepted every cycle.
- Word store: write occurs in the acceptance cycle; `resp_valid` follows one cycle later.
- Sub-word store:
  - cycle N: accept and read;
  - cycle N+1: RMW write, `req_ready`=0;
  - cycle N+2: `resp_valid`, and IDLE accepts the next request.
- Fault: `resp_valid`=1 and `fault`=1 one cycle after acceptance.
- `req_valid` low in IDLE: `mem_we`=0 and `resp_valid` next cycle = 0.
- A load accepted in the cycle after an RMW write sees the merged word, because dmem writes at that edge.
- Reset asserted during RMW: the write is abandoned, no partial word is written, and the FSM returns to IDLE asynchronously.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - H/HU access with `addr[0]`=1 faults;
  - W access with `addr[1:0]`≠00 faults.
- Not defined:
  - no misalignment faults;
  - offsets are forced to natural alignment: H uses `addr[1]` only, W ignores `addr[1:0]`;
  - illegal-size and range faults remain.

## Test plan
- Memory word 0x8000_7F80 at 0x100:
  - LB 0x100 -> `resp_rdata`=0xFFFF_FF80;
  - LBU 0x103 -> 0x0000_0080;
  - LH 0x102 -> 0xFFFF_8000;
  - LHU 0x100 -> 0x0000_7F80.
  - Each with `resp_valid` one cycle after acceptance.
- Word 0x1122_3344 at 0x200, SB 0xAB to 0x201 -> `req_ready` low exactly one cycle, single `mem_we` pulse with `mem_wd`=0x1122_AB44. A following LW 0x200 returns 0x1122_AB44.
- SH 0xBEEF to 0x202 over 0x1122_3344 -> 0xBEEF_3344. A back-to-back SB that follows is held one cycle, then accepted.
- SW 0xDEAD_BEEF to 0x102:
  - with `LSU_MISALIGN_TRAP_EN`: `fault`=1, no `mem_we`;
  - without it: word 0x100 is written with 0xDEAD_BEEF.
- LW with `req_size`=011, and SW to 0x0010_0000 with `DMEM_POWER`=18 -> `fault`=1, `resp_rdata`=0, no write.
- Assert `rst` during the RMW cycle of SB 0x55 to 0x300 -> word at 0x300 is unchanged, `req_ready`=1, `resp_valid`=0 after reset.
